gray_ptr_rx: RTL and testbench

GRAY_PTR_RX -- requirements
Module: gray_ptr_rx

---
 rtl/gray_ptr_rx.sv | 108 ++++++++++
 tb/tb_gray_ptr_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_rx.sv
`default_nettype none
// ============================================================================
//  Module   : gray_ptr_rx
//  Brief    : Receives an asynchronous Gray pointer through a two-stage
//             synchronizer, decodes it to binary and reports step size,
//             update pulses and illegal multi-bit transitions.
//             Optional check logic: define GRAY_PTR_RX_ERR_CHECK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module gray_ptr_rx #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] g_in,
    input  logic         err_clr,
    output logic [N-1:0] g_sync,
    output logic [N-1:0] b_out,
    output logic         upd,
    output logic [N-1:0] delta,
    output logic         err
);

    localparam logic [1:0] WARM_DONE = 2'd3;

    logic [N-1:0] s1_q, s2_q, s3_q;
    logic [N-1:0] b_out_q, delta_q;
    logic         upd_q;
    logic [1:0]   warm_q;

    logic [N-1:0] bin_d, prev_d, diff_d, delta_d;
    logic         warm_done_d, changed_d, upd_d;

    // Gray-to-binary for the current and previous synchronized values
    always_comb begin
        bin_d  = '0;
        prev_d = '0;
        bin_d[N-1]  = s2_q[N-1];
        prev_d[N-1] = s3_q[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            bin_d[i]  = s2_q[i] ^ bin_d[i+1];
            prev_d[i] = s3_q[i] ^ prev_d[i+1];
        end
    end

    always_comb begin
        diff_d      = s2_q ^ s3_q;
        warm_done_d = (warm_q == WARM_DONE);
        changed_d   = (diff_d != '0);
        upd_d       = warm_done_d && changed_d;
        delta_d     = upd_d ? (bin_d - prev_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            b_out_q <= '0;
            delta_q <= '0;
            upd_q   <= 1'b0;
            warm_q  <= 2'd0;
        end else begin
            s1_q    <= g_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            b_out_q <= bin_d;
            delta_q <= delta_d;
            upd_q   <= upd_d;
            if (!warm_done_d) begin
                warm_q <= warm_q + 2'd1;
            end
        end
    end

`ifdef GRAY_PTR_RX_ERR_CHECK_EN
    logic err_q;
    logic multi_bit_d;

    // x & (x-1) is non-zero exactly when more than one bit of x is set
    always_comb begin
        multi_bit_d = ((diff_d & (diff_d - 1'b1)) != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (warm_done_d && multi_bit_d) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err            = 1'b0;
`endif

    assign g_sync = s2_q;
    assign b_out  = b_out_q;
    assign upd    = upd_q;
    assign delta  = delta_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_ptr_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gray_ptr_rx
//  Brief    : Self-checking bench for gray_ptr_rx (N=4) with a sample-history
//             reference model and directed literal checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gray_ptr_rx;

    localparam int N = 4;
`ifdef GRAY_PTR_RX_ERR_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] g_in = '0;
    logic         err_clr = 1'b0;
    logic [N-1:0] g_sync, b_out, delta;
    logic         upd, err;

    gray_ptr_rx #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .g_in    (g_in),
        .err_clr (err_clr),
        .g_sync  (g_sync),
        .b_out   (b_out),
        .upd     (upd),
        .delta   (delta),
        .err     (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int upd_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Binary value of a Gray code: XOR of all right shifts
    function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
        logic [N-1:0] b = g;
        for (int s = 1; s < N; s++) b = b ^ (g >> s);
        return b;
    endfunction

    // Model: history of g_in sampled at each edge (zeroed by reset)
    logic [N-1:0] hist [0:2];
    int           since = 0;
    logic         mv = 1'b0;
    logic [N-1:0] m_gs, m_b, m_d;
    logic         m_upd, m_err;

    always @(posedge clk) begin
        if (!rst_n) begin
            hist[0] <= '0; hist[1] <= '0; hist[2] <= '0;
            since <= 0;
            m_gs <= '0; m_b <= '0; m_d <= '0; m_upd <= 1'b0; m_err <= 1'b0;
            mv <= 1'b1;
        end else begin
            hist[0] <= g_in; hist[1] <= hist[0]; hist[2] <= hist[1];
            since <= (since < 100) ? since + 1 : since;
            m_gs <= hist[0];
            m_b  <= g2b(hist[1]);
            if (since >= 3 && hist[1] != hist[2]) begin
                m_upd <= 1'b1;
                m_d   <= g2b(hist[1]) - g2b(hist[2]);
            end else begin
                m_upd <= 1'b0;
                m_d   <= '0;
            end
            if (ERR_EN && since >= 3 && $countones(hist[1] ^ hist[2]) > 1)
                m_err <= 1'b1;
            else if (err_clr)
                m_err <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mv) begin
            chk("g_sync", 32'(g_sync), 32'(m_gs));
            chk("b_out",  32'(b_out),  32'(m_b));
            chk("upd",    32'(upd),    32'(m_upd));
            chk("delta",  32'(delta),  32'(m_d));
            chk("err",    32'(err),    32'(m_err));
            if (upd === 1'b1) upd_cnt++;
        end
    end

    logic [N-1:0] cap_d, cap_b;
    logic         cap_err;

    // Apply a new Gray value and hold it; report the edge index of the first upd
    task automatic drive(input logic [N-1:0] g, input int hold, output int upd_edge);
        @(negedge clk);
        g_in = g;
        upd_edge = 0;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (upd === 1'b1 && upd_edge == 0) begin
                upd_edge = i;
                cap_d = delta; cap_b = b_out; cap_err = err;
            end
        end
    endtask

    initial begin
        int e;
        int base;
        // Reset and idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_b_out", 32'(b_out), 32'd0);
        chk("idle_upd_cnt", upd_cnt, 0);
        chk("idle_err", 32'(err), 32'd0);

        // Single-step increments: 1, 2, 3
        drive(4'b0001, 4, e);
        chk("inc1_latency", e, 3); chk("inc1_b", 32'(cap_b), 32'd1); chk("inc1_d", 32'(cap_d), 32'd1);
        drive(4'b0011, 4, e);
        chk("inc2_latency", e, 3); chk("inc2_b", 32'(cap_b), 32'd2); chk("inc2_d", 32'(cap_d), 32'd1);
        drive(4'b0010, 4, e);
        chk("inc3_latency", e, 3); chk("inc3_b", 32'(cap_b), 32'd3); chk("inc3_d", 32'(cap_d), 32'd1);
        chk("inc_upd_cnt", upd_cnt, 3);

        // Walk to 15 then wrap to 0
        drive(4'b1010, 4, e);
        chk("to12_b", 32'(cap_b), 32'd12); chk("to12_d", 32'(cap_d), 32'd9);
        drive(4'b1000, 4, e);
        chk("to15_b", 32'(cap_b), 32'd15);
        drive(4'b0000, 4, e);
        chk("wrap_b", 32'(cap_b), 32'd0); chk("wrap_d", 32'(cap_d), 32'd1);

        // Decrement 2 -> 1
        drive(4'b0001, 4, e);
        drive(4'b0011, 4, e);
        drive(4'b0001, 4, e);
        chk("dec_b", 32'(cap_b), 32'd1); chk("dec_d", 32'(cap_d), 32'hF);
        chk("legal_err", 32'(err), 32'd0);

        // Illegal two-bit step 0 -> 2
        drive(4'b0000, 4, e);
        drive(4'b0011, 6, e);
        chk("ill_edge", e, 3); chk("ill_b", 32'(cap_b), 32'd2); chk("ill_d", 32'(cap_d), 32'd2);
        chk("ill_err_same_edge", 32'(cap_err), 32'(ERR_EN));
        chk("ill_err_sticky", 32'(err), 32'(ERR_EN));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);

        // Clear coincident with a new illegal step (2 -> 0): set wins
        g_in = 4'b0000;
        repeat (2) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("coinc_upd", 32'(upd), 32'd1);
        chk("coinc_d", 32'(delta), 32'd14);
        chk("coinc_err", 32'(err), 32'(ERR_EN));
        repeat (3) @(negedge clk);

        // Build up b_out = 5, then reset mid-run with g_in held
        drive(4'b0001, 4, e);
        drive(4'b0011, 4, e);
        drive(4'b0010, 4, e);
        drive(4'b0110, 4, e);
        drive(4'b0111, 4, e);
        chk("pre_rst_b", 32'(b_out), 32'd5);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_outputs", {g_sync, b_out, delta, 3'(upd), 1'(err)}, '0);
        rst_n = 1'b1;
        base = upd_cnt;
        repeat (2) @(negedge clk);
        chk("post_rst_edge2_b", 32'(b_out), 32'd0);
        @(negedge clk);
        chk("post_rst_edge3_b", 32'(b_out), 32'd5);
        repeat (6) @(negedge clk);
        chk("post_rst_no_upd", upd_cnt - base, 0);
        chk("post_rst_err", 32'(err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
